imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader: writer side of the instruction memory that the single-cycle core fetches from.
- Accepts a byte stream over a valid/ready handshake and writes 8-bit instruction codes into instruction memory starting at address 0.
- Holds the core in reset until the program is completely written. Flags malformed streams.

Parameters:
- ADDR_W, 5, instruction memory address width; depth = 2^ADDR_W bytes.
- DATA_W, 8, instruction code width. Fixed to 8: checksum and length fields are byte-wide.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- In_Valid  input  1  stream byte valid.
- In_Data  input  8  stream byte.
- In_Ready  output  1  loader can accept; a byte transfers on a rising edge with In_Valid=1 and In_Ready=1.
- Mem_WE  output  1  instruction memory write enable.
- Mem_Addr  output  ADDR_W  instruction memory write address.
- Mem_WData  output  8  instruction memory write data.
- Cpu_Reset  output  1  reset to the core; high until load succeeds.
- Done  output  1  program loaded; core released.
- Error  output  1  stream rejected; sticky until Reset.

Behaviour:
- Clocking and reset: one clock (Clk). Reset is synchronous and active-high; all state changes occur on the rising edge of Clk.
- Reset values: state=IDLE, Mem_WE=0, Mem_Addr=0, Mem_WData=0, Cpu_Reset=1, Done=0, Error=0, byte counter=0, checksum accumulator=0.
- In_Ready is combinational: 1 in IDLE, LOAD or CHECK, and 0 while Reset=1 or in FLUSH, DONE or ERR.
- Stream format: length byte N, then N instruction bytes, then (build-dependent) one checksum byte.
- IDLE, on accept:
  - N=0 or N>2^ADDR_W -> ERR.
  - Otherwise latch N, counter=0 -> LOAD.
- LOAD, on accept:
  - Registered write: in the cycle after acceptance, Mem_WE=1, Mem_Addr=counter, Mem_WData=byte. Latency is 1 cycle from handshake edge to write-visible cycle.
  - Counter increments. When the accepted byte is byte N-1 -> CHECK (feature on) or FLUSH (feature off).
- Mem_WE is 0 in every cycle not immediately following a LOAD acceptance.
- Stalls (In_Valid=0) hold state and counter. No timeout.
- Address wrap: counter never exceeds N-1 ≤ 2^ADDR_W-1, so no wrap occurs. N=2^ADDR_W fills the memory exactly, with the last address all-ones.
- FLUSH: one cycle for the last write to commit -> DONE.
- DONE: Done=1, Cpu_Reset=0 from the first DONE cycle. In_Ready=0. Extra In_Valid bytes are ignored. Held until Reset.
- ERR: Error=1, Cpu_Reset=1, In_Ready=0, no writes. Held until Reset.
- Reset mid-load: returns to IDLE next edge, Cpu_Reset=1, any pending Mem_WE cleared. Already-written memory words are not scrubbed; the next load overwrites them.
- Done and Error are never both 1.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Accumulator = 8-bit sum mod 256 of all N instruction bytes, cleared in IDLE.
  - CHECK accepts one checksum byte C. If (accumulator + C) mod 256 == 0 -> DONE, else -> ERR.
  - The last instruction write has committed by the CHECK accept edge, so FLUSH is not used.
- Undefined: no accumulator. LOAD -> FLUSH -> DONE. The CHECK state is absent.

Test Plan:
- Basic load, feature off: stream 03,41,82,C3 with In_Valid held 1 -> writes (0,41),(1,82),(2,C3) on consecutive cycles. Done=1 and Cpu_Reset=0 two cycles after the last accept. Error=0.
- Checksum pass, feature on: 02,10,20, then C=D0 -> DONE. Same stream with C=D1 -> Error=1, Cpu_Reset stays 1, Done=0.
- Length errors: first byte 00 -> ERR the next cycle, no Mem_WE. With ADDR_W=5, first byte 21 -> ERR. First byte 20 followed by 32 bytes -> last write at address 1F, then DONE.
- Backpressure and stalls: toggle In_Valid 1/0 every cycle during 04,A,B,C,D -> exactly 4 writes at addresses 0..3, in order. After DONE, In_Ready=0 and further bytes produce no Mem_WE.
- Reset mid-load: assert Reset for one cycle after 2 of 5 bytes -> IDLE, Cpu_Reset=1, Mem_WE=0. A fresh stream 01,7F then writes (0,7F) and reaches DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length-prefixed byte stream into IMEM, holds core in reset.
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              In_Valid,
   input  logic [DATA_W-1:0] In_Data,
   output logic              In_Ready,
   output logic              Mem_WE,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_WData,
   output logic              Cpu_Reset,
   output logic              Done,
   output logic              Error
);

   localparam int unsigned Depth = 1 << ADDR_W;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck,
`endif
      StFlush,
      StDone,
      StErr
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0]   sum_q, sum_d;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
         last_q  <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   always_comb begin
      In_Ready = 1'b0;
      if (!Reset) begin
         case (state_q)
            StIdle, StLoad: In_Ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck:        In_Ready = 1'b1;
`endif
            default:        In_Ready = 1'b0;
         endcase
      end
   end

   assign accept = In_Valid && In_Ready;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         StIdle: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d = '0;
`endif
            if (accept) begin
               if (In_Data == '0 || 32'(In_Data) > Depth) begin
                  state_d = StErr;
               end else begin
                  // Store index of the final byte so N = Depth fits in ADDR_W bits
                  last_d  = ADDR_W'(In_Data - 1'b1);
                  cnt_d   = '0;
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = cnt_q;
               wdata_d = In_Data;
               cnt_d   = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = sum_q + In_Data;
               if (cnt_q == last_q) state_d = StCheck;
`else
               if (cnt_q == last_q) state_d = StFlush;
`endif
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         StCheck: begin
            if (accept) begin
               state_d = (DATA_W'(sum_q + In_Data) == '0) ? StDone : StErr;
            end
         end
`endif
         StFlush: state_d = StDone;
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   assign Mem_WE    = we_q;
   assign Mem_Addr  = addr_q;
   assign Mem_WData = wdata_q;
   assign Done      = (state_q == StDone);
   assign Error     = (state_q == StErr);
   assign Cpu_Reset = (state_q != StDone);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=5); follows IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       In_Valid;
   logic [7:0] In_Data;
   logic       In_Ready;
   logic       Mem_WE;
   logic [4:0] Mem_Addr;
   logic [7:0] Mem_WData;
   logic       Cpu_Reset;
   logic       Done;
   logic       Error;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   logic [4:0] log_a[$];
   logic [7:0] log_d[$];
   int         log_t[$];

   imem_loader #(.ADDR_W(5), .DATA_W(8)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .In_Valid  (In_Valid),
      .In_Data   (In_Data),
      .In_Ready  (In_Ready),
      .Mem_WE    (Mem_WE),
      .Mem_Addr  (Mem_Addr),
      .Mem_WData (Mem_WData),
      .Cpu_Reset (Cpu_Reset),
      .Done      (Done),
      .Error     (Error)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc_n <= cyc_n + 1;

   always @(negedge Clk) begin
      if (Mem_WE === 1'b1) begin
         log_a.push_back(Mem_Addr);
         log_d.push_back(Mem_WData);
         log_t.push_back(cyc_n);
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
      log_t.delete();
   endtask

   task automatic do_reset();
      Reset    = 1'b1;
      In_Valid = 1'b0;
      In_Data  = 8'h00;
      cyc();
      Reset = 1'b0;
      #1;
      clear_log();
   endtask

   // Present one byte for one cycle, leaving In_Valid high afterwards.
   task automatic send(input logic [7:0] b);
      In_Valid = 1'b1;
      In_Data  = b;
      checks++;
      if (In_Ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready byte=%h In_Ready=%b expected 1", b, In_Ready);
      end
      cyc();
   endtask

   // Finish a stream: checksum byte when enabled, otherwise the flush cycle.
   task automatic close(input logic [7:0] csum);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(csum);
      In_Valid = 1'b0;
`else
      In_Valid = 1'b0;
      checks++;
      if (Done !== 1'b0) begin
         errors++;
         $display("FAIL flush_done_low Done=%b expected 0 (csum %h unused)", Done, csum);
      end
      cyc();
`endif
   endtask

   task automatic test_reset();
      Reset    = 1'b1;
      In_Valid = 1'b0;
      In_Data  = 8'h00;
      cyc();
      checks++;
      if (In_Ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_in_reset got %b expected 0", In_Ready);
      end
      Reset = 1'b0;
      #1;
      checks++;
      if ({In_Ready, Mem_WE, Mem_Addr, Mem_WData, Cpu_Reset, Done, Error} !==
          {1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values rdy=%b we=%b a=%h d=%h cr=%b done=%b err=%b expected 1 0 00 00 1 0 0",
                  In_Ready, Mem_WE, Mem_Addr, Mem_WData, Cpu_Reset, Done, Error);
      end
      clear_log();
   endtask

   task automatic test_basic();
      do_reset();
      send(8'h03);
      send(8'h41);
      send(8'h82);
      send(8'hC3);
      close(8'h7A);
      checks++;
      if ({Done, Cpu_Reset, Error, In_Ready} !== 4'b1000) begin
         errors++;
         $display("FAIL basic_done done=%b cr=%b err=%b rdy=%b expected 1 0 0 0",
                  Done, Cpu_Reset, Error, In_Ready);
      end
      checks++;
      if (log_a.size() != 3) begin
         errors++;
         $display("FAIL basic_count got %0d expected 3", log_a.size());
      end else begin
         checks++;
         if ({log_a[0], log_d[0], log_a[1], log_d[1], log_a[2], log_d[2]} !==
             {5'd0, 8'h41, 5'd1, 8'h82, 5'd2, 8'hC3}) begin
            errors++;
            $display("FAIL basic_writes got (%h,%h)(%h,%h)(%h,%h) expected (00,41)(01,82)(02,C3)",
                     log_a[0], log_d[0], log_a[1], log_d[1], log_a[2], log_d[2]);
         end
         checks++;
         if (log_t[1] != log_t[0] + 1 || log_t[2] != log_t[1] + 1) begin
            errors++;
            $display("FAIL basic_consecutive got t=%0d,%0d,%0d expected consecutive",
                     log_t[0], log_t[1], log_t[2]);
         end
      end
   endtask

   task automatic test_checksum();
      do_reset();
      send(8'h02);
      send(8'h10);
      send(8'h20);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'hD0);
      In_Valid = 1'b0;
      checks++;
      if ({Done, Error, Cpu_Reset} !== 3'b100) begin
         errors++;
         $display("FAIL csum_pass done=%b err=%b cr=%b expected 1 0 0", Done, Error, Cpu_Reset);
      end
      do_reset();
      send(8'h02);
      send(8'h10);
      send(8'h20);
      send(8'hD1);
      In_Valid = 1'b0;
      cyc();
      checks++;
      if ({Done, Error, Cpu_Reset, In_Ready} !== 4'b0110) begin
         errors++;
         $display("FAIL csum_bad done=%b err=%b cr=%b rdy=%b expected 0 1 1 0",
                  Done, Error, Cpu_Reset, In_Ready);
      end
`else
      In_Valid = 1'b0;
      cyc();
      checks++;
      if ({Done, Error, Cpu_Reset} !== 3'b100) begin
         errors++;
         $display("FAIL nocsum_done done=%b err=%b cr=%b expected 1 0 0", Done, Error, Cpu_Reset);
      end
`endif
      checks++;
      if (log_a.size() != 2) begin
         errors++;
         $display("FAIL csum_writes got %0d expected 2", log_a.size());
      end
   endtask

   task automatic test_length();
      do_reset();
      send(8'h00);
      In_Valid = 1'b0;
      checks++;
      if ({Error, Done, Cpu_Reset, In_Ready} !== 4'b1010) begin
         errors++;
         $display("FAIL len0_err err=%b done=%b cr=%b rdy=%b expected 1 0 1 0",
                  Error, Done, Cpu_Reset, In_Ready);
      end
      cyc();
      checks++;
      if (log_a.size() != 0) begin
         errors++;
         $display("FAIL len0_nowrite got %0d writes expected 0", log_a.size());
      end
      do_reset();
      send(8'h21);
      In_Valid = 1'b0;
      checks++;
      if ({Error, Done} !== 2'b10) begin
         errors++;
         $display("FAIL len21_err err=%b done=%b expected 1 0", Error, Done);
      end
      do_reset();
      send(8'h20);
      for (int i = 0; i < 32; i++) send(8'(i + 8'h40));
      // Bytes 0x40..0x5F sum to 0x9F0, checksum byte 0x10.
      close(8'h10);
      checks++;
      if ({Done, Error} !== 2'b10) begin
         errors++;
         $display("FAIL full_done done=%b err=%b expected 1 0", Done, Error);
      end
      checks++;
      if (log_a.size() != 32) begin
         errors++;
         $display("FAIL full_count got %0d expected 32", log_a.size());
      end else begin
         checks++;
         if ({log_a[31], log_d[31], log_a[0], log_d[0]} !== {5'h1F, 8'h5F, 5'h00, 8'h40}) begin
            errors++;
            $display("FAIL full_ends got last (%h,%h) first (%h,%h) expected (1F,5F) (00,40)",
                     log_a[31], log_d[31], log_a[0], log_d[0]);
         end
      end
   endtask

   task automatic test_stalls();
      do_reset();
      send(8'h04);
      In_Valid = 1'b0;
      cyc();
      send(8'h0A);
      In_Valid = 1'b0;
      cyc();
      send(8'h0B);
      In_Valid = 1'b0;
      cyc();
      checks++;
      if ({Mem_WE, Done} !== 2'b00) begin
         errors++;
         $display("FAIL stall_hold we=%b done=%b expected 0 0", Mem_WE, Done);
      end
      send(8'h0C);
      In_Valid = 1'b0;
      cyc();
      send(8'h0D);
      close(8'hD2);
      checks++;
      if ({Done, In_Ready} !== 2'b10) begin
         errors++;
         $display("FAIL stall_done done=%b rdy=%b expected 1 0", Done, In_Ready);
      end
      checks++;
      if (log_a.size() != 4) begin
         errors++;
         $display("FAIL stall_count got %0d expected 4", log_a.size());
      end else begin
         checks++;
         if ({log_a[0], log_d[0], log_a[1], log_d[1], log_a[2], log_d[2], log_a[3], log_d[3]} !==
             {5'd0, 8'h0A, 5'd1, 8'h0B, 5'd2, 8'h0C, 5'd3, 8'h0D}) begin
            errors++;
            $display("FAIL stall_writes got (%h,%h)(%h,%h)(%h,%h)(%h,%h) expected 0..3 A..D",
                     log_a[0], log_d[0], log_a[1], log_d[1], log_a[2], log_d[2], log_a[3], log_d[3]);
         end
      end
      In_Valid = 1'b1;
      In_Data  = 8'hFF;
      repeat (3) cyc();
      In_Valid = 1'b0;
      cyc();
      checks++;
      if (log_a.size() != 4 || Done !== 1'b1 || In_Ready !== 1'b0) begin
         errors++;
         $display("FAIL after_done writes=%0d done=%b rdy=%b expected 4 1 0",
                  log_a.size(), Done, In_Ready);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      send(8'h05);
      send(8'h11);
      send(8'h22);
      In_Valid = 1'b0;
      Reset    = 1'b1;
      cyc();
      checks++;
      if ({Cpu_Reset, Mem_WE, Done, In_Ready} !== 4'b1000) begin
         errors++;
         $display("FAIL midreset cr=%b we=%b done=%b rdy=%b expected 1 0 0 0",
                  Cpu_Reset, Mem_WE, Done, In_Ready);
      end
      Reset = 1'b0;
      #1;
      clear_log();
      send(8'h01);
      send(8'h7F);
      close(8'h81);
      checks++;
      if ({Done, Error, Cpu_Reset} !== 3'b100) begin
         errors++;
         $display("FAIL reload_done done=%b err=%b cr=%b expected 1 0 0", Done, Error, Cpu_Reset);
      end
      checks++;
      if (log_a.size() != 1) begin
         errors++;
         $display("FAIL reload_count got %0d expected 1", log_a.size());
      end else begin
         checks++;
         if ({log_a[0], log_d[0]} !== {5'd0, 8'h7F}) begin
            errors++;
            $display("FAIL reload_write got (%h,%h) expected (00,7F)", log_a[0], log_d[0]);
         end
      end
   endtask

   initial begin
      Reset    = 1'b1;
      In_Valid = 1'b0;
      In_Data  = 8'h00;
      test_reset();
      test_basic();
      test_checksum();
      test_length();
      test_stalls();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
